// File: rtl/mac_pe_dbuf_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe_dbuf_if
// Brief    : Port bundle of one systolic MAC cell (weights, data, partial sums).
// Revision : 1.0 - initial release
// ============================================================================
interface mac_pe_dbuf_if #(
    parameter int DATA_W = 8,
    parameter int WT_W   = 8,
    parameter int ACC_W  = 32
);
    logic              control;
    logic [WT_W-1:0]   wt_path_in;
    logic [WT_W-1:0]   wt_path_out;
    logic              wt_swap;
    logic              wt_swap_out;
    logic              data_valid_in;
    logic [DATA_W-1:0] data_in;
    logic [ACC_W-1:0]  acc_in;
    logic              data_valid_out;
    logic [DATA_W-1:0] data_out;
    logic [ACC_W-1:0]  acc_out;
    logic              sat_clr;
    logic              sat_flag;

    modport master (
        output control, wt_path_in, wt_swap, data_valid_in, data_in, acc_in, sat_clr,
        input  wt_path_out, wt_swap_out, data_valid_out, data_out, acc_out, sat_flag
    );

    modport slave (
        input  control, wt_path_in, wt_swap, data_valid_in, data_in, acc_in, sat_clr,
        output wt_path_out, wt_swap_out, data_valid_out, data_out, acc_out, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/mac_pe_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe_dbuf
// Brief    : Weight-stationary MAC cell with shadow/active weights, valid-qualified
//            data, signed/unsigned arithmetic and optional saturation.
// Revision : 1.0 - initial release
// ============================================================================
module mac_pe_dbuf #(
    parameter int DATA_W   = 8,
    parameter int WT_W     = 8,
    parameter int ACC_W    = 32,   // must be >= DATA_W + WT_W
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst,
    mac_pe_dbuf_if.slave bus
);
    localparam int c_PROD_W = DATA_W + WT_W;

    logic [WT_W-1:0]     r_shadow_wt;
    logic [WT_W-1:0]     r_active_wt;
    logic [WT_W-1:0]     r_wt_path;
    logic                r_swap;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [ACC_W-1:0]    r_acc;
    logic                r_sat;

    logic [c_PROD_W-1:0] w_data_ext;
    logic [c_PROD_W-1:0] w_wt_ext;
    logic [c_PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_ovf;

    // Operands are widened to the full product width so the low c_PROD_W bits
    // of the multiply are the exact product in either number system.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_data_ext = {{WT_W{bus.data_in[DATA_W-1]}}, bus.data_in};
            assign w_wt_ext   = {{DATA_W{r_active_wt[WT_W-1]}}, r_active_wt};
            assign w_prod_ext = ACC_W'($signed(w_prod));
            assign w_sum      = bus.acc_in + w_prod_ext;
            assign w_ovf      = (bus.acc_in[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                                (w_sum[ACC_W-1] != bus.acc_in[ACC_W-1]);
        end else begin : g_unsigned
            logic w_carry;
            assign w_data_ext         = {{WT_W{1'b0}}, bus.data_in};
            assign w_wt_ext           = {{DATA_W{1'b0}}, r_active_wt};
            assign w_prod_ext         = ACC_W'(w_prod);
            assign {w_carry, w_sum}   = {1'b0, bus.acc_in} + {1'b0, w_prod_ext};
            assign w_ovf              = w_carry;
        end
    endgenerate

    assign w_prod = w_data_ext * w_wt_ext;

    generate
        if (SATURATE != 0) begin : g_sat
            logic [ACC_W-1:0] w_sat_val;
            // A signed overflow can only occur when both addends share a sign,
            // so the sign of acc_in tells which rail to clamp to.
            assign w_sat_val  = (SIGNED == 0)        ? {ACC_W{1'b1}} :
                                bus.acc_in[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                                       {1'b0, {(ACC_W-1){1'b1}}};
            assign w_acc_next = w_ovf ? w_sat_val : w_sum;
        end else begin : g_wrap
            assign w_acc_next = w_sum;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_wt <= '0;
            r_active_wt <= '0;
            r_wt_path   <= '0;
            r_swap      <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
        end else begin
            if (bus.control) begin
                r_shadow_wt <= bus.wt_path_in;
                r_wt_path   <= bus.wt_path_in;
            end
            if (bus.wt_swap) begin
                r_active_wt <= r_shadow_wt;
            end
            r_swap  <= bus.wt_swap;
            r_valid <= bus.data_valid_in;
            if (bus.data_valid_in) begin
                r_data <= bus.data_in;
                r_acc  <= w_acc_next;
            end else begin
                r_acc  <= bus.acc_in;
            end
            if (bus.data_valid_in && w_ovf) begin
                r_sat <= 1'b1;
            end else if (bus.sat_clr) begin
                r_sat <= 1'b0;
            end
        end
    end

    assign bus.wt_path_out    = r_wt_path;
    assign bus.wt_swap_out    = r_swap;
    assign bus.data_valid_out = r_valid;
    assign bus.data_out       = r_data;
    assign bus.acc_out        = r_acc;
    assign bus.sat_flag       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_pe_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_pe_dbuf
// Brief    : Self-checking bench for mac_pe_dbuf in all four SIGNED/SATURATE modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_pe_dbuf;
    // instance index: 0 signed/wrap, 1 signed/sat, 2 unsigned/wrap, 3 unsigned/sat
    logic        clk;
    logic        rst;
    logic        control;
    logic [7:0]  wt_in;
    logic        swap;
    logic        vld;
    logic [7:0]  din;
    logic [31:0] ain;
    logic        clr;

    logic [31:0] acc_o  [4];
    logic        sat_o  [4];
    logic        dv_o   [4];
    logic        swo_o  [4];
    logic [7:0]  dout_o [4];
    logic [7:0]  wpo_o  [4];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mac_pe_dbuf_if #(.DATA_W(8), .WT_W(8), .ACC_W(32)) bus ();
        assign bus.control       = control;
        assign bus.wt_path_in    = wt_in;
        assign bus.wt_swap       = swap;
        assign bus.data_valid_in = vld;
        assign bus.data_in       = din;
        assign bus.acc_in        = ain;
        assign bus.sat_clr       = clr;
        assign acc_o[g]  = bus.acc_out;
        assign sat_o[g]  = bus.sat_flag;
        assign dv_o[g]   = bus.data_valid_out;
        assign swo_o[g]  = bus.wt_swap_out;
        assign dout_o[g] = bus.data_out;
        assign wpo_o[g]  = bus.wt_path_out;
        mac_pe_dbuf #(
            .DATA_W(8), .WT_W(8), .ACC_W(32),
            .SIGNED((g < 2) ? 1 : 0), .SATURATE(g % 2)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    // ---------------- reference model (mathematical, per instance) ----------
    logic [7:0]  m_shadow, m_active, m_wpo, m_dout;
    logic        m_swo, m_dv;
    logic [31:0] m_acc [4];
    logic        m_sat [4];

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_wpo = '0; m_dout = '0;
        m_swo = 1'b0; m_dv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = '0;
            m_sat[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        longint a, d, w, s, lo, hi, r;
        for (int k = 0; k < 4; k++) begin
            if (!vld) begin
                m_acc[k] = ain;
                if (clr) m_sat[k] = 1'b0;
            end else begin
                if (k < 2) begin
                    a = $signed(ain); d = $signed(din); w = $signed(m_active);
                    lo = -64'sd2147483648; hi = 64'sd2147483647;
                end else begin
                    a = ain; d = din; w = m_active;
                    lo = 64'sd0; hi = 64'sd4294967295;
                end
                s = a + d * w;
                r = s;
                if (s > hi || s < lo) begin
                    m_sat[k] = 1'b1;
                    if (k % 2 == 1) r = (s > hi) ? hi : lo;
                end else if (clr) begin
                    m_sat[k] = 1'b0;
                end
                m_acc[k] = r[31:0];
            end
        end
        m_dv = vld;
        if (vld) m_dout = din;
        if (swap) m_active = m_shadow;
        if (control) begin
            m_shadow = wt_in;
            m_wpo    = wt_in;
        end
        m_swo = swap;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int g = 0; g < 4; g++) begin
            chk("acc",  g, acc_o[g], m_acc[g]);
            chk("sat",  g, 32'(sat_o[g]), 32'(m_sat[g]));
            chk("dv",   g, 32'(dv_o[g]), 32'(m_dv));
            chk("dout", g, 32'(dout_o[g]), 32'(m_dout));
            chk("wpo",  g, 32'(wpo_o[g]), 32'(m_wpo));
            chk("swo",  g, 32'(swo_o[g]), 32'(m_swo));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ctrl;
        logic [7:0]  wt;
        logic        swp;
        logic        v;
        logic [7:0]  d;
        logic [31:0] a;
        logic        c;
        logic [7:0]  e_wpo;
        logic        e_dv;
        logic [7:0]  e_dout;
        logic [31:0] e_acc [4];
        logic        e_sat_s;
        logic        e_sat_u;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ctrl, input logic [7:0] wt, input logic swp, input logic v,
                       input logic [7:0] d, input logic [31:0] a, input logic c,
                       input logic [7:0] e_wpo, input logic e_dv, input logic [7:0] e_dout,
                       input logic [31:0] sw, input logic [31:0] ss, input logic [31:0] uw,
                       input logic [31:0] us, input logic sat_s, input logic sat_u);
        vec_t x;
        x.ctrl = ctrl; x.wt = wt; x.swp = swp; x.v = v; x.d = d; x.a = a; x.c = c;
        x.e_wpo = e_wpo; x.e_dv = e_dv; x.e_dout = e_dout;
        x.e_acc[0] = sw; x.e_acc[1] = ss; x.e_acc[2] = uw; x.e_acc[3] = us;
        x.e_sat_s = sat_s; x.e_sat_u = sat_u;
        tbl.push_back(x);
    endtask

    initial begin
        // basic load / swap / MAC
        add(1, 8'h02, 0, 0, 8'h00, 32'h0,        0, 8'h02, 0, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 32'h0,        0, 8'h02, 0, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        add(0, 8'h00, 0, 1, 8'h01, 32'h2,        0, 8'h02, 1, 8'h01, 32'h4, 32'h4, 32'h4, 32'h4, 0, 0);
        // load during compute, swap coincident with valid
        add(1, 8'h03, 0, 1, 8'h04, 32'h3,        0, 8'h03, 1, 8'h04, 32'd11, 32'd11, 32'd11, 32'd11, 0, 0);
        add(1, 8'h03, 0, 1, 8'h04, 32'h3,        0, 8'h03, 1, 8'h04, 32'd11, 32'd11, 32'd11, 32'd11, 0, 0);
        add(0, 8'h00, 1, 1, 8'h04, 32'h3,        0, 8'h03, 1, 8'h04, 32'd11, 32'd11, 32'd11, 32'd11, 0, 0);
        add(0, 8'h00, 0, 1, 8'h04, 32'h3,        0, 8'h03, 1, 8'h04, 32'd15, 32'd15, 32'd15, 32'd15, 0, 0);
        // bubble
        add(0, 8'h00, 0, 0, 8'h09, 32'h7,        0, 8'h03, 0, 8'h04, 32'h7, 32'h7, 32'h7, 32'h7, 0, 0);
        // signed vs unsigned weight -3 / 253
        add(1, 8'hFD, 0, 0, 8'h00, 32'h0,        0, 8'hFD, 0, 8'h04, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 32'h0,        0, 8'hFD, 0, 8'h04, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        add(0, 8'h00, 0, 1, 8'h05, 32'h0,        0, 8'hFD, 1, 8'h05, 32'hFFFFFFF1, 32'hFFFFFFF1, 32'h4F1, 32'h4F1, 0, 0);
        // overflow cases with weight 1
        add(1, 8'h01, 0, 0, 8'h00, 32'h0,        0, 8'h01, 0, 8'h05, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 32'h0,        0, 8'h01, 0, 8'h05, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        add(0, 8'h00, 0, 1, 8'h01, 32'h7FFFFFFF, 0, 8'h01, 1, 8'h01, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 1, 0);
        add(0, 8'h00, 0, 1, 8'h01, 32'h0,        1, 8'h01, 1, 8'h01, 32'h1, 32'h1, 32'h1, 32'h1, 0, 0);
        add(0, 8'h00, 0, 1, 8'h01, 32'hFFFFFFFF, 0, 8'h01, 1, 8'h01, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1);
        add(0, 8'h00, 0, 1, 8'h01, 32'hFFFFFFFF, 1, 8'h01, 1, 8'h01, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1);
        add(0, 8'h00, 0, 1, 8'h80, 32'h80000000, 0, 8'h01, 1, 8'h80, 32'h7FFFFF80, 32'h80000000, 32'h80000080, 32'h80000080, 1, 1);

        rst = 1'b1; control = 0; wt_in = 0; swap = 0; vld = 0; din = 0; ain = 0; clr = 0;
        model_reset();
        #2;
        for (int g = 0; g < 4; g++) begin
            chk("init_acc", g, acc_o[g], 32'h0);
            chk("init_sat", g, 32'(sat_o[g]), 32'h0);
            chk("init_dv",  g, 32'(dv_o[g]), 32'h0);
            chk("init_wpo", g, 32'(wpo_o[g]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            control = tbl[i].ctrl; wt_in = tbl[i].wt; swap = tbl[i].swp; vld = tbl[i].v;
            din = tbl[i].d; ain = tbl[i].a; clr = tbl[i].c;
            step();
            for (int g = 0; g < 4; g++) begin
                chk("tbl_acc",  i * 4 + g, acc_o[g], tbl[i].e_acc[g]);
                chk("tbl_sat",  i * 4 + g, 32'(sat_o[g]), 32'((g < 2) ? tbl[i].e_sat_s : tbl[i].e_sat_u));
                chk("tbl_dv",   i * 4 + g, 32'(dv_o[g]), 32'(tbl[i].e_dv));
                chk("tbl_dout", i * 4 + g, 32'(dout_o[g]), 32'(tbl[i].e_dout));
                chk("tbl_wpo",  i * 4 + g, 32'(wpo_o[g]), 32'(tbl[i].e_wpo));
                chk("tbl_swo",  i * 4 + g, 32'(swo_o[g]), 32'(tbl[i].swp));
            end
        end

        // asynchronous reset asserted between edges while streaming
        for (int j = 0; j < 2; j++) begin
            control = 1; wt_in = 8'($urandom); swap = 0; vld = 1;
            din = 8'($urandom); ain = $urandom; clr = 0;
            step();
            check_model();
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("arst_acc",  g, acc_o[g], 32'h0);
            chk("arst_sat",  g, 32'(sat_o[g]), 32'h0);
            chk("arst_dv",   g, 32'(dv_o[g]), 32'h0);
            chk("arst_dout", g, 32'(dout_o[g]), 32'h0);
            chk("arst_wpo",  g, 32'(wpo_o[g]), 32'h0);
            chk("arst_swo",  g, 32'(swo_o[g]), 32'h0);
        end
        #1 rst = 1'b0;
        control = 0; wt_in = 0; swap = 0; vld = 1; din = 8'd3; ain = 32'd1; clr = 0;
        step();
        for (int g = 0; g < 4; g++) begin
            chk("post_rst_acc",  g, acc_o[g], 32'd1);
            chk("post_rst_dv",   g, 32'(dv_o[g]), 32'h1);
            chk("post_rst_dout", g, 32'(dout_o[g]), 32'd3);
        end

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            control = ($urandom_range(0, 2) == 0);
            wt_in   = 8'($urandom);
            swap    = ($urandom_range(0, 3) == 0);
            vld     = ($urandom_range(0, 3) != 0);
            din     = 8'($urandom);
            clr     = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0:       ain = 32'h7FFFFF00 + $urandom_range(0, 255);
                1:       ain = 32'h80000000 + $urandom_range(0, 255);
                2:       ain = 32'hFFFFFF00 + $urandom_range(0, 255);
                default: ain = $urandom;
            endcase
            step();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_pe_dbuf.md
Name: mac_pe_dbuf

Overview:
Parametrised processing element for the systolic-array matrix multiplier. It is the next generation of the weight-stationary MAC cell. Additions over the previous cell:
- Double-buffered (shadow/active) weights, so the next tile's weights load while the current tile computes.
- Valid-qualified data flow.
- Signed or unsigned arithmetic.
- Optional saturation with a sticky overflow flag.

Cells tile in a 2-D grid: data and valid flow horizontally, partial sums flow vertically, weights daisy-chain down columns.

Parameters:
- DATA_W, 8, data operand width.
- WT_W, 8, weight width.
- ACC_W, 32, accumulator and partial-sum width. Must satisfy ACC_W >= DATA_W+WT_W.
- SIGNED, 1, 1 = two's-complement operands and sums, 0 = unsigned.
- SATURATE, 0, 1 = clamp the sum on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- control  in  1  weight-load enable, broadcast to the column.
- wt_path_in  in  WT_W  weight from the cell above.
- wt_path_out  out  WT_W  registered weight to the cell below.
- wt_swap  in  1  copy shadow weight into the active weight.
- wt_swap_out  out  1  registered wt_swap to the neighbour.
- data_valid_in  in  1  data_in/acc_in qualifier.
- data_in  in  DATA_W  activation from the left.
- acc_in  in  ACC_W  partial sum from above.
- data_valid_out  out  1  registered valid to the right.
- data_out  out  DATA_W  registered activation to the right.
- acc_out  out  ACC_W  registered partial sum downward.
- sat_clr  in  1  synchronous clear of sat_flag.
- sat_flag  out  1  sticky overflow indicator.

Behaviour:
- Reset (rst=1, asynchronous): clears to 0, immediately and independent of clk:
  - internal registers shadow_wt and active_wt;
  - outputs wt_path_out, wt_swap_out, data_valid_out, data_out, acc_out, sat_flag.
- Reset mid-operation: all in-flight state is lost. The first edge after rst deasserts behaves as from power-up.
- Weight load, control=1 at an edge:
  - shadow_wt <= wt_path_in and wt_path_out <= wt_path_in.
  - One-cycle per-cell chain latency; N cycles fill an N-deep column.
- Weight load, control=0: shadow_wt and wt_path_out hold.
- Swap: wt_swap=1 at an edge sets active_wt <= shadow_wt, using the pre-edge shadow value. wt_swap_out <= wt_swap every edge.
- control=1 and wt_swap=1 at the same edge: active_wt takes the old shadow, shadow_wt takes the new wt_path_in.
- Compute is independent of control. Loading weights does not stall computation, which is the new behaviour versus the old cell.
- data_valid_in=1 at an edge:
  - P = data_in * active_wt (pre-edge active_wt), width DATA_W+WT_W.
  - Operands and P are sign-extended if SIGNED=1, zero-extended otherwise.
  - S = acc_in + ext(P), then acc_out <= S.
  - data_out <= data_in; data_valid_out <= 1.
  - Latency from inputs to outputs is 1 cycle.
- data_valid_in=1 with wt_swap=1 at the same edge: the product uses the old active_wt. The new weight applies from the next edge.
- Bubble (data_valid_in=0):
  - data_valid_out <= 0 and data_out holds.
  - acc_out <= acc_in unmodified (partial sum passes through).
  - No overflow is checked.
- Overflow detection:
  - SIGNED=1: acc_in and ext(P) have the same sign and S has a different sign.
  - SIGNED=0: carry out of bit ACC_W-1.
- Overflow with SATURATE=1: acc_out clamps.
  - SIGNED=1: to 2^(ACC_W-1)-1 on positive overflow, to -2^(ACC_W-1) on negative overflow.
  - SIGNED=0: to 2^ACC_W-1.
- Overflow with SATURATE=0: acc_out wraps.
- sat_flag:
  - Set at the edge where a valid overflow occurs, regardless of SATURATE.
  - Cleared at an edge with sat_clr=1.
  - Overflow and sat_clr at the same edge: the set wins.
- No combinational paths from inputs to outputs.

Test Plan (defaults unless stated):
1. Basic load/swap/MAC:
   - Stimulus: control=1, wt_path_in=2 for one edge; next edge wt_swap=1; then valid with data_in=1, acc_in=2.
   - Required: acc_out=4, data_out=1, data_valid_out=1 one cycle after the valid edge; wt_path_out=2 one cycle after the load edge.
2. Load during compute:
   - Stimulus: active weight 2; stream valid data_in=4, acc_in=3 while loading 3 into shadow (control=1).
   - Required: outputs stay 11 until wt_swap; the first valid after the swap edge gives 15; a swap coincident with valid still gives 11.
3. Signed:
   - Stimulus: weight 8'hFD (-3), data_in=5, acc_in=0.
   - Required: acc_out=32'hFFFFFFF1. With SIGNED=0 the same stimulus gives 32'h000004F1.
4. Overflow:
   - Stimulus: weight 1, data_in=1, acc_in=32'h7FFFFFFF.
   - Required with SATURATE=1: acc_out=32'h7FFFFFFF, sat_flag=1.
   - Required with SATURATE=0: acc_out=32'h80000000, sat_flag=1.
   - Then sat_clr=1 with no overflow: sat_flag=0 the next cycle.
5. Bubble:
   - Stimulus: valid=0, acc_in=7, data_in=9.
   - Required: acc_out=7, data_valid_out=0, data_out keeps its prior value.
6. Async reset:
   - Stimulus: assert rst between clock edges during streaming.
   - Required: all outputs 0 before the next edge. After deassert, valid data_in=3, acc_in=1 gives acc_out=1, since active_wt is 0.
